// File: rtl/register_slice.sv
// Two-entry valid/ready register slice: main register drives the output, skid absorbs
// the one word accepted while the consumer stalls. Every output comes straight from a flop.
module register_slice #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  // Encoding equals occupancy so count is the state register itself.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = StOne;
        end
      end
      StOne: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = StTwo;
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush drops occupancy only; stored words stay put and any in_fire is lost.
    if (flush) begin
      state_d = StEmpty;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      main_q      <= RESET_DATA;
      skid_q      <= RESET_DATA;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != StTwo);
      out_valid_q <= (state_d != StEmpty);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign count     = state_q;

endmodule

// File: tb/tb_register_slice.sv
// Directed table, hand sequences for a 32-bit instance, and a randomised scoreboard run.
module tb_register_slice;

  localparam logic [7:0]  NRst = 8'hA5;
  localparam logic [31:0] WRst = 32'h5A5A_0F0F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       n_rst, n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [7:0] n_in_data, n_out_data;
  logic [1:0] n_count;

  // 32-bit instance
  logic        w_rst, w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [31:0] w_in_data, w_out_data;
  logic [1:0]  w_count;

  register_slice #(.WIDTH(8), .RESET_DATA(NRst)) u_narrow (
    .clk       (clk),
    .rst       (n_rst),
    .flush     (n_flush),
    .in_valid  (n_in_valid),
    .in_ready  (n_in_ready),
    .in_data   (n_in_data),
    .out_valid (n_out_valid),
    .out_ready (n_out_ready),
    .out_data  (n_out_data),
    .count     (n_count)
  );

  register_slice #(.WIDTH(32), .RESET_DATA(WRst)) u_wide (
    .clk       (clk),
    .rst       (w_rst),
    .flush     (w_flush),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .in_data   (w_in_data),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .out_data  (w_out_data),
    .count     (w_count)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic       rst;
    logic       flush;
    logic       iv;
    logic [7:0] din;
    logic       ordy;
    logic       ov;
    logic       ir;
    logic [1:0] cnt;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic fl, input logic iv, input logic [7:0] din,
                     input logic ordy, input logic ov, input logic ir, input logic [1:0] cnt,
                     input logic [7:0] dout);
    vec_t v;
    v.rst = rst; v.flush = fl; v.iv = iv; v.din = din; v.ordy = ordy;
    v.ov = ov; v.ir = ir; v.cnt = cnt; v.dout = dout;
    vecs.push_back(v);
  endtask

  // Scoreboard for the random phase; fires are judged mid-cycle when inputs are stable.
  logic [7:0] model_q[$];
  logic       sb_en = 1'b0;
  logic       last_in_fire = 1'b0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    if (sb_en) begin
      check("rnd_count", 32'(n_count), 32'(model_q.size()));
      check("rnd_in_ready", 32'(n_in_ready), 32'(model_q.size() < 2));
      if (prev_hold) check("rnd_stable", 32'(n_out_data), 32'(prev_data));
      prev_hold = n_out_valid && !n_out_ready;
      prev_data = n_out_data;
      if (n_out_valid && n_out_ready) begin
        if (model_q.size() == 0) check("rnd_underflow", 32'd1, 32'd0);
        else check("rnd_order", 32'(n_out_data), 32'(model_q.pop_front()));
      end
      last_in_fire = n_in_valid && n_in_ready;
      if (last_in_fire) model_q.push_back(n_in_data);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_rst = 1'b1; n_flush = 1'b0; n_in_valid = 1'b0; n_in_data = '0; n_out_ready = 1'b0;
    w_rst = 1'b1; w_flush = 1'b0; w_in_valid = 1'b0; w_in_data = '0; w_out_ready = 1'b0;

    //  rst fl iv din    ordy  ov ir cnt dout
    add(1, 0, 1, 8'h00, 0,    0, 0, 0, NRst);
    add(1, 0, 1, 8'h00, 0,    0, 0, 0, NRst);
    add(1, 0, 1, 8'h00, 0,    0, 0, 0, NRst);
    add(0, 0, 0, 8'h00, 0,    0, 1, 0, NRst);
    for (int i = 1; i <= 8; i++) add(0, 0, 1, 8'(i), 1, 1, 1, 1, 8'(i));
    add(0, 0, 0, 8'h00, 1,    0, 1, 0, 8'h08);
    // backpressure
    add(0, 0, 1, 8'h11, 0,    1, 1, 1, 8'h11);
    add(0, 0, 1, 8'h22, 0,    1, 0, 2, 8'h11);
    add(0, 0, 1, 8'h33, 0,    1, 0, 2, 8'h11);
    add(0, 0, 1, 8'h33, 1,    1, 1, 1, 8'h22);
    add(0, 0, 1, 8'h33, 1,    1, 1, 1, 8'h33);
    add(0, 0, 0, 8'h00, 1,    0, 1, 0, 8'h33);
    // flush from TWO with 44 offered
    add(0, 0, 1, 8'h55, 0,    1, 1, 1, 8'h55);
    add(0, 0, 1, 8'h66, 0,    1, 0, 2, 8'h55);
    add(0, 1, 1, 8'h44, 0,    0, 1, 0, 8'h55);
    add(0, 0, 0, 8'h00, 0,    0, 1, 0, 8'h55);
    // flush from ONE discards a simultaneous in_fire
    add(0, 0, 1, 8'h77, 0,    1, 1, 1, 8'h77);
    add(0, 1, 1, 8'h44, 0,    0, 1, 0, 8'h77);
    add(0, 0, 0, 8'h00, 0,    0, 1, 0, 8'h77);
    // flush with simultaneous out_fire
    add(0, 0, 1, 8'h88, 0,    1, 1, 1, 8'h88);
    add(0, 1, 0, 8'h00, 1,    0, 1, 0, 8'h88);
    // reset overrides flush in TWO
    add(0, 0, 1, 8'h99, 0,    1, 1, 1, 8'h99);
    add(0, 0, 1, 8'hAA, 0,    1, 0, 2, 8'h99);
    add(1, 1, 1, 8'hBB, 1,    0, 0, 0, NRst);
    add(0, 0, 0, 8'h00, 0,    0, 1, 0, NRst);

    foreach (vecs[i]) begin
      n_rst = vecs[i].rst; n_flush = vecs[i].flush; n_in_valid = vecs[i].iv;
      n_in_data = vecs[i].din; n_out_ready = vecs[i].ordy;
      @(posedge clk); #1;
      check($sformatf("v%0d_out_valid", i), 32'(n_out_valid), 32'(vecs[i].ov));
      check($sformatf("v%0d_in_ready", i), 32'(n_in_ready), 32'(vecs[i].ir));
      check($sformatf("v%0d_count", i), 32'(n_count), 32'(vecs[i].cnt));
      check($sformatf("v%0d_out_data", i), 32'(n_out_data), 32'(vecs[i].dout));
    end

    // Wide instance: reset in the middle of a stalled sequence.
    @(posedge clk); #1;
    check("w_rst_data", w_out_data, WRst);
    w_rst = 1'b0;
    @(posedge clk); #1;
    check("w_in_ready_rise", 32'(w_in_ready), 32'd1);
    w_in_valid = 1'b1; w_in_data = 32'hDEAD_BEEF; w_out_ready = 1'b0;
    @(posedge clk); #1;
    check("w_first", w_out_data, 32'hDEAD_BEEF);
    w_in_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    check("w_count2", 32'(w_count), 32'd2);
    check("w_ready_low", 32'(w_in_ready), 32'd0);
    w_rst = 1'b1;
    @(posedge clk); #1;
    check("w_mid_rst_count", 32'(w_count), 32'd0);
    check("w_mid_rst_data", w_out_data, WRst);
    check("w_mid_rst_valid", 32'(w_out_valid), 32'd0);
    w_rst = 1'b0; w_in_valid = 1'b0;
    @(posedge clk); #1;
    check("w_ready_again", 32'(w_in_ready), 32'd1);
    w_in_valid = 1'b1; w_in_data = 32'h1234_5678; w_out_ready = 1'b1;
    @(posedge clk); #1;
    check("w_word", w_out_data, 32'h1234_5678);
    check("w_word_valid", 32'(w_out_valid), 32'd1);
    w_in_valid = 1'b0;
    @(posedge clk); #1;
    check("w_alone_valid", 32'(w_out_valid), 32'd0);
    check("w_alone_count", 32'(w_count), 32'd0);

    // Random phase on the narrow instance, starting empty.
    n_in_valid = 1'b0; n_out_ready = 1'b0;
    sb_en = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      if (!(n_in_valid && !last_in_fire)) begin
        n_in_valid = ($urandom_range(0, 3) != 0);
        n_in_data  = 8'($urandom);
      end
      n_out_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    n_in_valid = 1'b0; n_out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    sb_en = 1'b0;
    check("rnd_drained_model", 32'(model_q.size()), 32'd0);
    check("rnd_drained_count", 32'(n_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/register_slice.md
# register_slice

Parametrised register stage with a valid/ready handshake and an internal skid entry. It carries a WIDTH-bit word from an upstream producer to a downstream consumer at full throughput. It breaks every combinational path between the two sides, including the ready path, and can be flushed synchronously. It replaces the plain enable-loaded register at pipeline boundaries where the consumer can stall.

## Interface

Parameters:
- WIDTH, default 8: data word width in bits; legal values are 1 or greater.
- RESET_DATA, default 0: WIDTH-bit value loaded into both data registers on reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- flush  input  1  synchronous clear of held entries; takes effect at the next edge.
- in_valid  input  1  upstream word present on in_data.
- in_ready  output  1  slice can accept a word; driven directly from a flop.
- in_data  input  WIDTH  upstream word.
- out_valid  output  1  out_data holds a valid word; driven directly from a flop.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  main data register.
- count  output  2  occupancy: 0, 1 or 2 entries.

## Operation

- A transfer on either side happens when valid and ready are both high at a rising edge. These are called in_fire and out_fire.
- The slice holds two storage registers: main, which drives out_data, and skid.
- States follow the occupancy:
  - EMPTY: count 0, out_valid 0, in_ready 1.
  - ONE: count 1, out_valid 1, in_ready 1.
  - TWO: count 2, out_valid 1, in_ready 0.
- Transitions:
  - EMPTY, in_fire: main <= in_data, go to ONE.
  - ONE, in_fire with out_fire: main <= in_data, stay in ONE.
  - ONE, in_fire only: skid <= in_data, go to TWO.
  - ONE, out_fire only: go to EMPTY.
  - TWO, out_fire: main <= skid, go to ONE. in_valid is ignored because in_ready is 0.
  - Any state, no fire: hold all state.
- Ordering is strict FIFO. A word is never duplicated or dropped except by flush or rst.
- Flush:
  - At the edge where flush=1 and rst=0, go to EMPTY with in_ready 1.
  - A simultaneous in_fire is discarded and a simultaneous out_fire completes normally.
  - Data registers keep their values.
- Reset:
  - At any edge with rst=1, go to EMPTY and load main and skid with RESET_DATA.
  - in_ready goes to 0 and stays 0 while rst is high.
  - Reset overrides flush and all handshakes, including in the middle of a transfer sequence.
- out_data changes only on an edge where out_valid=0 or out_fire occurs. It is therefore stable while out_valid=1 and out_ready=0.
- No arithmetic is performed; data passes bit-exact at every WIDTH.

## Timing

- Reset values:
  - out_valid 0
  - in_ready 0
  - count 0
  - out_data RESET_DATA
- in_ready rises at the first edge sampled with rst=0, i.e. one cycle after rst deasserts.
- Latency is 1 cycle: a word accepted at edge N is presented with out_valid=1 after edge N.
- Throughput is 1 word per cycle while out_ready is held high. The skid entry stays empty in that case.
- in_ready falls one cycle after the first stalled accept, which takes the slice into TWO. It rises again in the cycle after the out_fire that leaves TWO.
- There is no combinational path from out_ready to in_ready, from in_valid to out_valid, or from in_data to out_data. All outputs come straight from flops.
- Upstream must hold in_valid and in_data stable while in_valid=1 and in_ready=0. The slice does not depend on this for correctness.

## Test plan

- Reset: hold rst=1 for 3 cycles with in_valid=1 and WIDTH=8, RESET_DATA=8'hA5. Required: out_valid=0, in_ready=0, count=0 and out_data=8'hA5 throughout. in_ready=1 one cycle after rst falls.
- Streaming: out_ready=1, push 8'h01..8'h08 on consecutive cycles. Required: out_data shows 01..08 on consecutive cycles, each one cycle after its accept; count never exceeds 1; in_ready stays 1.
- Backpressure: out_ready=0, push 8'h11 then 8'h22, then offer 8'h33. Required: count=2, in_ready=0 and 8'h33 held off. Raise out_ready: output order is 11, 22, 33 with no gap once 33 is accepted.
- Flush: with count=2, assert flush together with in_valid=1 carrying 8'h44. Required: the next cycle shows count=0, out_valid=0 and in_ready=1; 8'h44 never appears on out_data.
- Wide and mid-operation reset: WIDTH=32, push 32'hDEADBEEF then 32'hCAFEF00D with out_ready=0, then pulse rst for 1 cycle. Required: count=0 and out_data=RESET_DATA. The next word pushed, 32'h12345678, emerges alone and bit-exact.
- Random: randomised in_valid/out_ready over 10k cycles against a scoreboard. Required: no loss, duplication or reorder; out_data stable whenever out_valid=1 and out_ready=0.
